// File: rtl/line_packetizer_if.sv
// Pixel input stream and packetized output stream of line_packetizer.
interface line_packetizer_if #(
    parameter int unsigned N = 2
);
    logic         frame_start;
    logic         axiiv;
    logic [15:0]  axiid;
    logic         axiov;
    logic [N-1:0] axiod;
    logic         overflow;
    logic         busy;

    modport master (
        output frame_start, axiiv, axiid,
        input  axiov, axiod, overflow, busy
    );

    modport slave (
        input  frame_start, axiiv, axiid,
        output axiov, axiod, overflow, busy
    );
endinterface

// File: rtl/line_packetizer.sv
// Buffers camera lines into two banks and streams each as a header-prefixed,
// LSB-chunk-first burst with a guaranteed idle gap between bursts.
module line_packetizer #(
    parameter int unsigned N              = 2,
    parameter int unsigned PIXELS_PER_PKT = 240,
    parameter int unsigned GAP_CYCLES     = 48
) (
    input  logic               clk,
    input  logic               rstn,
    line_packetizer_if.slave   bus
);

    localparam int unsigned CPB    = 8 / N;
    localparam int unsigned CW     = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned PW     = (PIXELS_PER_PKT > 1) ? $clog2(PIXELS_PER_PKT) : 1;
    localparam int unsigned NBYTES = 4 + 2 * PIXELS_PER_PKT;
    localparam int unsigned BW     = $clog2(NBYTES);
    localparam int unsigned GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_e;

    // read side
    state_e          state_q, state_d;
    logic            rb_q, rb_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [CW-1:0]   chunk_q, chunk_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            axiov_q, axiov_d;
    logic [N-1:0]    axiod_q, axiod_d;
    logic            busy_q, busy_d;
    logic            start, advance;
    logic [BW-1:0]   pix_off;
    logic [15:0]     pix_word;
    logic [7:0]      tx_byte;
    logic [1:0]      clr_full;

    // write side
    logic            wb_q, wb_d;
    logic            drop_q, drop_d;
    logic [PW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]     line_q, line_d;
    logic [15:0]     frame_q, frame_d;
    logic            overflow_q, overflow_d;
    logic [1:0]      full_q, full_d;
    logic [15:0]     hdr_line_q [2];
    logic [15:0]     hdr_line_d [2];
    logic [15:0]     hdr_frame_q [2];
    logic [15:0]     hdr_frame_d [2];
    logic [1:0]      set_full;
    logic [PW-1:0]   wr_base;
    logic [15:0]     line_base;
    logic [15:0]     frame_base;
    logic            drop_base;
    logic            drop_now;
    logic            mem_we;
    logic [PW-1:0]   mem_wa;
    logic [15:0]     mem_wd;

    logic [15:0]     mem_q [2][PIXELS_PER_PKT];

    // Write side: frame_start takes effect before a coincident pixel, and a
    // line's drop decision is made on its first pixel only.
    always_comb begin
        wr_base     = bus.frame_start ? '0 : wr_cnt_q;
        line_base   = bus.frame_start ? '0 : line_q;
        frame_base  = bus.frame_start ? frame_q + 16'd1 : frame_q;
        drop_base   = bus.frame_start ? 1'b0 : drop_q;
        wr_cnt_d    = wr_base;
        line_d      = line_base;
        frame_d     = frame_base;
        drop_d      = drop_base;
        wb_d        = wb_q;
        overflow_d  = overflow_q;
        hdr_line_d  = hdr_line_q;
        hdr_frame_d = hdr_frame_q;
        set_full    = 2'b00;
        drop_now    = drop_base;
        mem_we      = 1'b0;
        mem_wa      = wr_base;
        mem_wd      = bus.axiid;
        if (bus.axiiv) begin
            if (wr_base == '0) begin
                drop_now = full_q[wb_q];
                if (full_q[wb_q]) begin
                    overflow_d = 1'b1;
                end
            end
            mem_we = !drop_now;
            drop_d = drop_now;
            if (wr_base == PW'(PIXELS_PER_PKT - 1)) begin
                wr_cnt_d = '0;
                line_d   = line_base + 16'd1;
                drop_d   = 1'b0;
                if (!drop_now) begin
                    hdr_line_d[wb_q]  = line_base;
                    hdr_frame_d[wb_q] = frame_base;
                    set_full[wb_q]    = 1'b1;
                    wb_d              = !wb_q;
                end
            end else begin
                wr_cnt_d = wr_base + PW'(1);
            end
        end
    end

    // Read side: next state, next chunk position and the registered output chunk.
    always_comb begin
        state_d  = state_q;
        rb_d     = rb_q;
        byte_d   = byte_q;
        chunk_d  = chunk_q;
        gap_d    = gap_q;
        axiov_d  = 1'b0;
        axiod_d  = '0;
        clr_full = 2'b00;
        start    = 1'b0;
        advance  = 1'b0;
        pix_off  = '0;
        pix_word = '0;
        tx_byte  = '0;
        case (state_q)
            IDLE: start = full_q[rb_q];
            HDR, PAY: begin
                if (byte_q == BW'(NBYTES - 1) && chunk_q == CW'(CPB - 1)) begin
                    clr_full[rb_q] = 1'b1;
                    rb_d           = !rb_q;
                    gap_d          = '0;
                    state_d        = GAP;
                end else begin
                    advance = 1'b1;
                end
            end
            GAP: begin
                // last gap cycle doubles as the idle check so the gap is exact
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    start = full_q[rb_q];
                    if (!full_q[rb_q]) begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            byte_d  = '0;
            chunk_d = '0;
            state_d = HDR;
        end
        if (advance) begin
            if (chunk_q == CW'(CPB - 1)) begin
                chunk_d = '0;
                byte_d  = byte_q + BW'(1);
            end else begin
                chunk_d = chunk_q + CW'(1);
            end
            state_d = (byte_d < BW'(4)) ? HDR : PAY;
        end
        if (start || advance) begin
            axiov_d = 1'b1;
            if (byte_d < BW'(4)) begin
                case (byte_d[1:0])
                    2'd0:    tx_byte = hdr_frame_q[rb_q][15:8];
                    2'd1:    tx_byte = hdr_frame_q[rb_q][7:0];
                    2'd2:    tx_byte = hdr_line_q[rb_q][15:8];
                    default: tx_byte = hdr_line_q[rb_q][7:0];
                endcase
            end else begin
                pix_off  = byte_d - BW'(4);
                pix_word = mem_q[rb_q][PW'(pix_off >> 1)];
                tx_byte  = pix_off[0] ? pix_word[7:0] : pix_word[15:8];
            end
            axiod_d = N'(tx_byte >> (int'(chunk_d) * N));
        end
    end

    // Bank occupancy: completion and release touch different banks.
    always_comb begin
        full_d = (full_q & ~clr_full) | set_full;
        busy_d = (state_d != IDLE);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rb_q        <= 1'b0;
            byte_q      <= '0;
            chunk_q     <= '0;
            gap_q       <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= '0;
            busy_q      <= 1'b0;
            wb_q        <= 1'b0;
            drop_q      <= 1'b0;
            wr_cnt_q    <= '0;
            line_q      <= '0;
            frame_q     <= '0;
            overflow_q  <= 1'b0;
            full_q      <= 2'b00;
            hdr_line_q  <= '{default: '0};
            hdr_frame_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            rb_q        <= rb_d;
            byte_q      <= byte_d;
            chunk_q     <= chunk_d;
            gap_q       <= gap_d;
            axiov_q     <= axiov_d;
            axiod_q     <= axiod_d;
            busy_q      <= busy_d;
            wb_q        <= wb_d;
            drop_q      <= drop_d;
            wr_cnt_q    <= wr_cnt_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
            hdr_line_q  <= hdr_line_d;
            hdr_frame_q <= hdr_frame_d;
        end
    end

    // Pixel storage; contents are meaningless until a bank is marked full.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wb_q][mem_wa] <= mem_wd;
        end
    end

    assign bus.axiov    = axiov_q;
    assign bus.axiod    = axiod_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_line_packetizer.sv
// Bench for line_packetizer: a small-geometry and a default-geometry instance,
// checked against packets built directly from the pixels fed in.
module tb_line_packetizer;

    localparam int unsigned N   = 2;
    localparam int unsigned CPB = 8 / N;
    localparam int unsigned SP  = 4;
    localparam int unsigned SG  = 3;
    localparam int unsigned LP  = 240;
    localparam int unsigned LG  = 48;
    localparam int BURST_S = (4 + 2 * SP) * CPB;
    localparam int BURST_L = (4 + 2 * LP) * CPB;

    logic clk = 1'b0;
    logic rstn_s;
    logic rstn_l;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_packetizer_if #(.N(N)) bus_s ();
    line_packetizer_if #(.N(N)) bus_l ();

    line_packetizer #(.N(N), .PIXELS_PER_PKT(SP), .GAP_CYCLES(SG)) dut_s (
        .clk  (clk),
        .rstn (rstn_s),
        .bus  (bus_s)
    );

    line_packetizer #(.N(N), .PIXELS_PER_PKT(LP), .GAP_CYCLES(LG)) dut_l (
        .clk  (clk),
        .rstn (rstn_l),
        .bus  (bus_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- output monitor (both instances) ----------------
    logic         mv [2];
    logic [N-1:0] md [2];
    logic         mr [2];
    assign mv[0] = bus_s.axiov;
    assign mv[1] = bus_l.axiov;
    assign md[0] = bus_s.axiod;
    assign md[1] = bus_l.axiod;
    assign mr[0] = rstn_s;
    assign mr[1] = rstn_l;

    logic [7:0]   rx_b [2][8192];
    int           rx_nb [2]     = '{0, 0};
    int           bst_nb [2]    = '{0, 0};
    int           nb_bursts [2] = '{0, 0};
    int           cur_len [2]   = '{0, 0};
    int           low_len [2]   = '{0, 0};
    int           idle_nz [2]   = '{0, 0};
    logic [7:0]   acc [2]       = '{8'h00, 8'h00};
    int           b_len [2][64];
    int           b_gap [2][64];
    int           b_rise [2][64];
    logic [N-1:0] cur_ch [2][32];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!mr[d]) begin
                if (cur_len[d] > 0) rx_nb[d] = bst_nb[d];
                cur_len[d] = 0;
                low_len[d] = 0;
                acc[d]     = 8'h00;
            end else if (mv[d]) begin
                if (cur_len[d] == 0) begin
                    bst_nb[d] = rx_nb[d];
                    b_rise[d][nb_bursts[d] % 64] = cyc;
                    b_gap[d][nb_bursts[d] % 64]  = low_len[d];
                end
                if (cur_len[d] < 32) cur_ch[d][cur_len[d]] = md[d];
                acc[d] = acc[d] | (8'(md[d]) << ((cur_len[d] % CPB) * N));
                if ((cur_len[d] % CPB) == CPB - 1) begin
                    if (rx_nb[d] < 8192) rx_b[d][rx_nb[d]] = acc[d];
                    rx_nb[d]++;
                    acc[d] = 8'h00;
                end
                cur_len[d]++;
            end else begin
                if (md[d] != '0) idle_nz[d]++;
                if (cur_len[d] > 0) begin
                    b_len[d][nb_bursts[d] % 64] = cur_len[d];
                    nb_bursts[d]++;
                    cur_len[d] = 0;
                    low_len[d] = 0;
                end
                low_len[d]++;
            end
        end
    end

    // ---------------- reference packets ----------------
    logic [7:0]  ex_b [2][8192];
    int          ex_nb [2] = '{0, 0};
    logic [15:0] line_px [256];
    int          sc_b0;
    int          sc_y0;
    int          last_pix;

    task automatic push_byte(input int d, input logic [7:0] b);
        if (ex_nb[d] < 8192) ex_b[d][ex_nb[d]] = b;
        ex_nb[d]++;
    endtask

    // Expected packet: frame, line (big-endian), then each pixel high byte first.
    task automatic add_pkt(input int d, input logic [15:0] fr, input logic [15:0] ln, input int np);
        logic [15:0] px;
        push_byte(d, fr[15:8]);
        push_byte(d, fr[7:0]);
        push_byte(d, ln[15:8]);
        push_byte(d, ln[7:0]);
        for (int i = 0; i < np; i++) begin
            px = line_px[i];
            push_byte(d, px[15:8]);
            push_byte(d, px[7:0]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int d, input logic fs, input logic v, input logic [15:0] px);
        if (d == 0) begin
            bus_s.frame_start = fs;
            bus_s.axiiv       = v;
            bus_s.axiid       = px;
        end else begin
            bus_l.frame_start = fs;
            bus_l.axiiv       = v;
            bus_l.axiid       = px;
        end
    endtask

    task automatic pulse_fs(input int d);
        set_in(d, 1'b1, 1'b0, 16'h0000);
        tick();
        set_in(d, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic fill_line(input int np);
        for (int i = 0; i < np; i++) line_px[i] = 16'($urandom);
    endtask

    task automatic send_line(input int d, input int np, input bit gaps);
        for (int i = 0; i < np; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    set_in(d, 1'b0, 1'b0, 16'h0000);
                    tick();
                end
            end
            set_in(d, 1'b0, 1'b1, line_px[i]);
            tick();
        end
        last_pix = cyc;
        set_in(d, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic wait_bursts(input int d, input int target, input int budget, input string tag);
        for (int i = 0; i < budget && nb_bursts[d] < target; i++) tick();
        check_eq(tag, 32'(nb_bursts[d] >= target), 32'd1);
    endtask

    task automatic reset_dut(input int d);
        set_in(d, 1'b0, 1'b0, 16'h0000);
        if (d == 0) rstn_s = 1'b0; else rstn_l = 1'b0;
        tick();
        tick();
        if (d == 0) rstn_s = 1'b1; else rstn_l = 1'b1;
        tick();
    endtask

    task automatic begin_scn(input int d);
        sc_b0    = nb_bursts[d];
        sc_y0    = rx_nb[d];
        ex_nb[d] = rx_nb[d];
    endtask

    task automatic verify(input int d, input int nexp, input int blen, input string tag);
        int bad = 0;
        check_eq({tag, "_bursts"}, 32'(nb_bursts[d] - sc_b0), 32'(nexp));
        check_eq({tag, "_nbytes"}, 32'(rx_nb[d] - sc_y0), 32'(ex_nb[d] - sc_y0));
        for (int i = sc_y0; i < ex_nb[d] && i < 8192; i++) begin
            if (rx_b[d][i] !== ex_b[d][i]) bad++;
        end
        check_eq({tag, "_data"}, 32'(bad), 32'd0);
        for (int k = sc_b0; k < nb_bursts[d]; k++) begin
            check_eq({tag, "_len"}, 32'(b_len[d][k % 64]), 32'(blen));
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rstn_s = 1'b0;
        rstn_l = 1'b0;
        set_in(0, 1'b0, 1'b0, 16'h0000);
        set_in(1, 1'b0, 1'b0, 16'h0000);
        repeat (3) tick();
        check_eq("rst_axiov", 32'(bus_s.axiov), 32'd0);
        check_eq("rst_axiod", 32'(bus_s.axiod), 32'd0);
        check_eq("rst_overflow", 32'(bus_s.overflow), 32'd0);
        check_eq("rst_busy", 32'(bus_s.busy), 32'd0);
        check_eq("rst_axiov_l", 32'(bus_l.axiov), 32'd0);
        rstn_s = 1'b1;
        rstn_l = 1'b1;
        tick();

        // single line, fixed pixels
        begin_scn(0);
        pulse_fs(0);
        line_px[0] = 16'h1234;
        line_px[1] = 16'h5678;
        line_px[2] = 16'h9ABC;
        line_px[3] = 16'hDEF0;
        add_pkt(0, 16'd1, 16'd0, SP);
        send_line(0, SP, 1'b0);
        wait_bursts(0, sc_b0 + 1, 200, "s1_wait");
        verify(0, 1, BURST_S, "s1");
        check_eq("s1_latency", 32'(b_rise[0][sc_b0 % 64] - last_pix), 32'd1);
        check_eq("s1_chunk0", 32'(cur_ch[0][16]), 32'd2);
        check_eq("s1_chunk1", 32'(cur_ch[0][17]), 32'd0);
        check_eq("s1_chunk2", 32'(cur_ch[0][18]), 32'd1);
        check_eq("s1_chunk3", 32'(cur_ch[0][19]), 32'd0);
        check_eq("s1_overflow", 32'(bus_s.overflow), 32'd0);

        // three lines, output bursts back to back
        reset_dut(0);
        begin_scn(0);
        pulse_fs(0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) wait_bursts(0, sc_b0 + 1, 200, "s2_wait_bank");
            fill_line(SP);
            add_pkt(0, 16'd1, 16'(k), SP);
            send_line(0, SP, 1'b0);
        end
        wait_bursts(0, sc_b0 + 3, 400, "s2_wait");
        verify(0, 3, BURST_S, "s2");
        check_eq("s2_gap1", 32'(b_gap[0][(sc_b0 + 1) % 64]), 32'(SG));
        check_eq("s2_gap2", 32'(b_gap[0][(sc_b0 + 2) % 64]), 32'(SG));
        check_eq("s2_overflow", 32'(bus_s.overflow), 32'd0);

        // frame_start in the middle of a line
        reset_dut(0);
        begin_scn(0);
        pulse_fs(0);
        fill_line(2);
        send_line(0, 2, 1'b0);
        pulse_fs(0);
        fill_line(SP);
        add_pkt(0, 16'd2, 16'd0, SP);
        send_line(0, SP, 1'b0);
        wait_bursts(0, sc_b0 + 1, 200, "s4_wait");
        repeat (100) tick();
        verify(0, 1, BURST_S, "s4");

        // asynchronous reset during payload
        reset_dut(0);
        begin_scn(0);
        pulse_fs(0);
        fill_line(SP);
        send_line(0, SP, 1'b0);
        for (int i = 0; i < 50 && !bus_s.axiov; i++) tick();
        repeat (24) tick();
        check_eq("s5_pre_valid", 32'(bus_s.axiov), 32'd1);
        check_eq("s5_pre_busy", 32'(bus_s.busy), 32'd1);
        #2;
        rstn_s = 1'b0;
        #1;
        check_eq("s5_axiov", 32'(bus_s.axiov), 32'd0);
        check_eq("s5_axiod", 32'(bus_s.axiod), 32'd0);
        check_eq("s5_busy", 32'(bus_s.busy), 32'd0);
        @(posedge clk);
        #3;
        rstn_s = 1'b1;
        repeat (100) tick();
        check_eq("s5_quiet", 32'(nb_bursts[0] - sc_b0), 32'd0);
        check_eq("s5_quiet_bytes", 32'(rx_nb[0] - sc_y0), 32'd0);
        pulse_fs(0);
        fill_line(SP);
        add_pkt(0, 16'd1, 16'd0, SP);
        send_line(0, SP, 1'b0);
        wait_bursts(0, sc_b0 + 1, 200, "s5_wait");
        verify(0, 1, BURST_S, "s5");

        // overflow: third line arrives while both banks are full
        reset_dut(1);
        begin_scn(1);
        pulse_fs(1);
        for (int k = 0; k < 3; k++) begin
            fill_line(LP);
            if (k != 2) add_pkt(1, 16'd1, 16'(k), LP);
            send_line(1, LP, 1'b0);
            if (k == 1) check_eq("s3_ovf_before", 32'(bus_l.overflow), 32'd0);
        end
        check_eq("s3_ovf_set", 32'(bus_l.overflow), 32'd1);
        wait_bursts(1, sc_b0 + 1, 3000, "s3_wait_bank");
        fill_line(LP);
        add_pkt(1, 16'd1, 16'd3, LP);
        send_line(1, LP, 1'b0);
        wait_bursts(1, sc_b0 + 3, 6000, "s3_wait");
        verify(1, 3, BURST_L, "s3");
        check_eq("s3_ovf_sticky", 32'(bus_l.overflow), 32'd1);

        // randomized input gaps, ten lines, paced so a bank is always free
        reset_dut(1);
        begin_scn(1);
        pulse_fs(1);
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) wait_bursts(1, sc_b0 + k - 1, 4000, "s6_wait_bank");
            fill_line(LP);
            add_pkt(1, 16'd1, 16'(k), LP);
            send_line(1, LP, 1'b1);
        end
        wait_bursts(1, sc_b0 + 10, 6000, "s6_wait");
        verify(1, 10, BURST_L, "s6");
        check_eq("s6_overflow", 32'(bus_l.overflow), 32'd0);
        begin
            int short_gaps = 0;
            for (int k = sc_b0 + 1; k < nb_bursts[1]; k++) begin
                if (b_gap[1][k % 64] < int'(LG)) short_gaps++;
            end
            check_eq("s6_gap_min", 32'(short_gaps), 32'd0);
        end

        check_eq("idle_zero_s", 32'(idle_nz[0]), 32'd0);
        check_eq("idle_zero_l", 32'(idle_nz[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
